// File: rtl/kernel_pad_pkg.sv
// kernel_pad_pkg: shared stream dtype codes, header offsets
// and the kernel_pad output FSM state encoding.
package kernel_pad_pkg;

  localparam int DTYPE_WIDTH = 8;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = 8'h01;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = 8'h02;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = 8'h03;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = 8'h04;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER_START = 8'h05;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER       = 8'h06;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = 8'h80;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK   = 8'h80;

  localparam int HDR_AW = 8;
  localparam logic [HDR_AW-1:0] Image_num_cols = 8'd0;
  localparam logic [HDR_AW-1:0] Image_num_rows = 8'd1;

  typedef enum logic [2:0] {
    KPAD_PASS,
    KPAD_COLPAD,
    KPAD_RP_START,
    KPAD_RP_PIX,
    KPAD_RP_END,
    KPAD_RP_FEND
  } kpad_state_e;

  function automatic logic is_pixel(
    input logic [DTYPE_WIDTH-1:0] dt
  );
    return (dt & DTYPE_PIXEL_MASK) != '0;
  endfunction

endpackage

// File: rtl/rowbuffer.sv
// rowbuffer: single-row line store with one write port
// and one registered read port.
module rowbuffer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a write to a full
// FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;
  logic             push;
  logic             pull;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
  assign pull  = rd_en && !empty;
  assign push  = wr_en && (!full || pull);

  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pull) rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/kernel_pad.sv
// kernel_pad: re-expands kernel-stage frames by KERNEL_SIZE-1
// cols (and rows when KERNEL_PAD_ROWS_EN is defined).
module kernel_pad
  import kernel_pad_pkg::*;
#(
  parameter int KERNEL_SIZE    = 3,
  parameter int PIXEL_WIDTH    = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_COLS       = 1288,
  parameter int NUM_COLS_WIDTH = 11,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]  datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]  datao,
  output logic                   overflow
);

  localparam int PAD = KERNEL_SIZE - 1;
  localparam int FW  = DTYPE_WIDTH + DATA_WIDTH;
  localparam int CW  = NUM_COLS_WIDTH;

  typedef logic [CW:0] cnt_t;
  localparam cnt_t PAD_C = cnt_t'(PAD);
  localparam cnt_t C1    = cnt_t'(1);

  kpad_state_e state, nstate;

  logic                   full, empty, pop, hold;
  logic [FW-1:0]          fdata, held;
  logic [DTYPE_WIDTH-1:0] f_dt, held_dt, n_dt;
  logic [DATA_WIDTH-1:0]  f_dat, held_dat, n_dat;
  logic                   f_pix, hdr_hit, n_dv;
  logic                   frame_en;
  cnt_t                   cnt, ncnt, row, nrow;
  logic [CW-1:0]          col, ncols;
  logic [PIXEL_WIDTH-1:0] last_pix, rb_rdata;
  logic [HDR_AW-1:0]      haddr;

  assign {f_dt, f_dat}       = fdata;
  assign {held_dt, held_dat} = held;
  assign f_pix               = is_pixel(f_dt);

  function automatic logic [DATA_WIDTH-1:0] zext(
    input logic [PIXEL_WIDTH-1:0] p
  );
    return DATA_WIDTH'(p);
  endfunction

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FW)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (dvi),
    .wr_data({dtypei, datai}),
    .rd_en  (pop),
    .rd_data(fdata),
    .full   (full),
    .empty  (empty)
  );

`ifdef KERNEL_PAD_ROWS_EN
  localparam bit ROWS_EN = 1'b1;

  logic [CW-1:0] rb_raddr;

  // read address leads the emitted pixel index by one cycle
  assign rb_raddr = (state == KPAD_RP_PIX) ?
                    cnt[CW-1:0] + CW'(1) : '0;

  rowbuffer #(
    .ADDR_WIDTH(NUM_COLS_WIDTH),
    .DATA_WIDTH(PIXEL_WIDTH)
  ) u_rowbuf (
    .clk    (clk),
    .wr_en  (pop && f_pix),
    .wr_addr(col),
    .wr_data(f_dat[PIXEL_WIDTH-1:0]),
    .rd_addr(rb_raddr),
    .rd_data(rb_rdata)
  );
`else
  localparam bit ROWS_EN = 1'b0;

  assign rb_rdata = '0;
`endif

  assign hdr_hit = frame_en && (f_dt == DTYPE_HEADER) &&
                   ((haddr == Image_num_cols) ||
                    (ROWS_EN && haddr == Image_num_rows));

  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nrow   = row;
    pop    = 1'b0;
    hold   = 1'b0;
    n_dv   = 1'b0;
    n_dt   = '0;
    n_dat  = '0;
    unique case (state)
      KPAD_PASS: begin
        if (!empty) begin
          pop = 1'b1;
          if (frame_en && f_dt == DTYPE_ROW_END) begin
            hold   = 1'b1;
            ncnt   = '0;
            nstate = KPAD_COLPAD;
          end else if (ROWS_EN && PAD > 0 && frame_en &&
                       f_dt == DTYPE_FRAME_END) begin
            hold   = 1'b1;
            nrow   = '0;
            nstate = KPAD_RP_START;
          end else begin
            n_dv  = 1'b1;
            n_dt  = f_dt;
            n_dat = hdr_hit ?
                    f_dat + DATA_WIDTH'(PAD) : f_dat;
          end
        end
      end
      KPAD_COLPAD: begin
        n_dv = 1'b1;
        if (cnt == PAD_C) begin
          n_dt   = held_dt;
          n_dat  = held_dat;
          nstate = KPAD_PASS;
        end else begin
          n_dt  = DTYPE_PIXEL;
          n_dat = zext(last_pix);
          ncnt  = cnt + C1;
        end
      end
      KPAD_RP_START: begin
        n_dv   = 1'b1;
        n_dt   = DTYPE_ROW_START;
        ncnt   = '0;
        nstate = KPAD_RP_PIX;
      end
      KPAD_RP_PIX: begin
        n_dv  = 1'b1;
        n_dt  = DTYPE_PIXEL;
        n_dat = (cnt < {1'b0, ncols}) ?
                zext(rb_rdata) : zext(last_pix);
        ncnt  = cnt + C1;
        if (cnt == {1'b0, ncols} + PAD_C - C1)
          nstate = KPAD_RP_END;
      end
      KPAD_RP_END: begin
        n_dv   = 1'b1;
        n_dt   = DTYPE_ROW_END;
        nrow   = row + C1;
        nstate = (row == PAD_C - C1) ?
                 KPAD_RP_FEND : KPAD_RP_START;
      end
      KPAD_RP_FEND: begin
        n_dv   = 1'b1;
        n_dt   = held_dt;
        n_dat  = held_dat;
        nstate = KPAD_PASS;
      end
      default: nstate = KPAD_PASS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= KPAD_PASS;
      cnt      <= '0;
      row      <= '0;
      held     <= '0;
      frame_en <= 1'b0;
      col      <= '0;
      ncols    <= '0;
      last_pix <= '0;
      haddr    <= '0;
      dvo      <= 1'b0;
      dtypeo   <= '0;
      datao    <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= nstate;
      cnt    <= ncnt;
      row    <= nrow;
      dvo    <= n_dv;
      dtypeo <= n_dt;
      datao  <= n_dat;
      if (dvi && full && !pop) overflow <= 1'b1;
      if (hold) held <= fdata;
      if (pop) begin
        unique case (1'b1)
          f_pix: begin
            last_pix <= f_dat[PIXEL_WIDTH-1:0];
            if (col != CW'(MAX_COLS))
              col <= col + CW'(1);
          end
          f_dt == DTYPE_FRAME_START:
            frame_en <= enable;
          f_dt == DTYPE_ROW_START: begin
            col      <= '0;
            last_pix <= '0;
          end
          f_dt == DTYPE_ROW_END:
            ncols <= col;
          f_dt == DTYPE_HEADER_START:
            haddr <= '0;
          f_dt == DTYPE_HEADER:
            haddr <= haddr + HDR_AW'(1);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/kernel_pad.md
# kernel_pad

Restores the original image geometry after the kernel stage: consumes the dtype-tagged stream the kernel stage emits (with its shrunken header) and re-expands every frame by `KERNEL_SIZE-1` columns and rows. Padding replicates edge pixels (last pixel of each row, last row of each frame) and restores the header dimension fields. Sits directly downstream of any kernel-based filter, so later blocks see the sensor-native `num_cols`/`num_rows`.

## Interface
- `KERNEL_SIZE`, 3, kernel size of the upstream stage; `PAD = KERNEL_SIZE-1`.
- `PIXEL_WIDTH`, 10, significant pixel bits, taken from `datai[PIXEL_WIDTH-1:0]`.
- `DATA_WIDTH`, 16, stream word width.
- `MAX_COLS`, 1288, longest input row supported.
- `NUM_COLS_WIDTH`, 11, column address width.
- `FIFO_DEPTH`, 8, input skid FIFO depth, power of 2, must be ≥ `PAD`+2.
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: 0 = pure pass-through; sampled at `DTYPE_FRAME_START`.
- `dvi` in 1: input word valid.
- `dtypei` in `DTYPE_WIDTH`: input dtype.
- `datai` in `DATA_WIDTH`: input word.
- `dvo` out 1: output word valid.
- `dtypeo` out `DTYPE_WIDTH`: output dtype.
- `datao` out `DATA_WIDTH`: output word; padded pixels zero-extend `PIXEL_WIDTH` bits.
- `overflow` out 1: sticky, set on a write to a full FIFO; cleared only by `reset`.

## Operation
- All input words go through the skid FIFO. The output FSM pops at most one word per cycle. Inserted words are generated in the cycles where the FIFO is not popped.
- FSM states:
  - `PASS`: pop and forward.
  - On popping `DTYPE_ROW_END` with the frame enable latched, go to `COLPAD`; the `ROW_END` word is held.
  - `COLPAD`: emit `PAD` copies of the last pixel, then the held `ROW_END`, then return to `PASS`.
  - On popping `DTYPE_FRAME_END`, go to `ROWPAD`; the `FRAME_END` word is held.
  - `ROWPAD`: emit `PAD` rows. Each row is `ROW_START`, then `num_cols_in + PAD` pixels (pixels come from the row buffer; the pad tail repeats the final pixel), then `ROW_END`. After the last row, emit the held `FRAME_END` and return to `PASS`.
- Last-row capture:
  - Every popped pixel is written into the row buffer at the current column.
  - `col` is cleared at `ROW_START`.
  - At `ROW_END`, `col` is latched as `num_cols_in`.
  - A row with 0 pixels gives `num_cols_in = 0`; `ROWPAD` then emits `ROW_START`, `PAD` zero pixels, `ROW_END`.
- Header:
  - `header_addr` clears at `DTYPE_HEADER_START` and increments per `DTYPE_HEADER`.
  - When enabled and `header_addr` equals `Image_num_cols` or `Image_num_rows`, output `datai + PAD`, truncated to `DATA_WIDTH` (wrap allowed).
- When `enable` is latched 0: no padding, header unmodified, FSM stays in `PASS`.
- Other dtypes pass unchanged.
- Upstream guarantees each row gap is ≥ `PAD`+2 idle cycles and each frame gap is ≥ `PAD*(num_cols+PAD+2)`. Violations can only manifest as `overflow`; data order is still preserved up to the overflowing write, and the dropped word is the one written while full.

## Timing
- Reset values: `dvo=0`, `dtypeo=0`, `datao=0`, `overflow=0`, FSM=`PASS`, FIFO empty, `col=0`, `header_addr=0`.
- All outputs are registered.
- Pass-through latency is 2 cycles (FIFO write, then output register) when the FIFO is empty and the FSM is in `PASS`.
- `COLPAD` adds exactly `PAD`+1 output cycles per row.
- `ROWPAD` takes exactly `PAD*(num_cols_in+PAD+2)+1` cycles.
- Push and pop in the same cycle are legal at any fill level; a full FIFO with simultaneous pop accepts the write.
- Asserting `reset` mid-frame aborts the frame immediately; the FIFO is flushed and the next output begins at the next popped word.
- An `enable` change mid-frame takes effect at the next `FRAME_START`.

## Configuration
- `KERNEL_PAD_ROWS_EN` defined: the row buffer, the `ROWPAD` state and the `num_rows` header adjustment are compiled in.
- Undefined: column padding only. `FRAME_END` passes straight through, `num_rows` is unmodified, and no row buffer is instantiated.

## Structure
- Dtype codes, `DTYPE_PIXEL_MASK` and the `Image_num_cols`/`Image_num_rows` header offsets stay in the shared dtypes include. Add the FSM state encoding there as `KPAD_*` constants.
- Sub-modules:
  - The existing `rowbuffer` is reused for last-row storage, with `ADDR_WIDTH=NUM_COLS_WIDTH`.
  - A new `sync_fifo` (parameter `DEPTH`, `WIDTH`) holds the skid FIFO; its width is `DTYPE_WIDTH+DATA_WIDTH`.

## Test plan
- `KERNEL_SIZE=3`, `enable=1`, 4×3 pixel frame with header `num_cols=4`, `num_rows=3` → 6×5 frame; header reads 6/5; each row ends with its last pixel twice; rows 4–5 equal row 3 with its last pixel repeated.
- `enable=0`, same frame → output identical to input, delayed 2 cycles.
- Back-to-back rows with only 1 idle cycle between them → `overflow` rises at the first dropped write and stays high until `reset`.
- `reset` pulsed during `ROWPAD` → all outputs 0 the next cycle; a new frame then passes cleanly.
- Header `num_cols=16'hFFFF` with `PAD=2` → output `16'h0001`.
- Build without `KERNEL_PAD_ROWS_EN`, 4×3 frame → 6×3 output, `num_rows` header still 3.
